// File: rtl/digi_ota_pkg.sv
// Shared types and defaults for the time-shared OTA comparator scheduler.
package digi_ota_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT
  } state_e;

  localparam int DEF_SETTLE = 2;
  localparam int DEF_WINDOW = 8;

endpackage

// File: rtl/digi_ota_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NCH.
module digi_ota_rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]          req,
  input  logic [$clog2(NCH)-1:0]  ptr,
  output logic [$clog2(NCH)-1:0]  idx,
  output logic                    any
);

  localparam int IW = $clog2(NCH);

  logic [NCH-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW-1:0]  bi;
  logic [IW:0]    sum;

  always_comb begin
    // Rotate so that bit 0 is the channel at ptr; the lowest set bit is then the winner.
    rot = NCH'({req, req} >> ptr);
    any = 1'b0;
    off = '0;
    bi  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bi = IW'(i);
      if (!any && rot[bi]) begin
        any = 1'b1;
        off = bi;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NCH)) begin
      sum = sum - (IW+1)'(NCH);
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/digi_ota_scheduler.sv
// Time-shares one OTA comparator among NCH channel pairs: round-robin grant,
// settle, windowed integration, majority decision reported over valid/ready.
module digi_ota_scheduler
  import digi_ota_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int SETTLE = DEF_SETTLE,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         vip_ch,
  input  logic [NCH-1:0]         vin_ch,
  output logic                   ota_vip,
  output logic                   ota_vin,
  input  logic                   ota_out,
  input  logic                   ota_vld,
  output logic [NCH-1:0]         gnt,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic                   res_bit,
  output logic [CW-1:0]          res_ones,
  output logic [CW-1:0]          res_vcnt
);

  localparam int IW   = $clog2(NCH);
  localparam int CMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int CNTW = $clog2(CMAX + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   vcnt_q, vcnt_d;
  logic            ota_vip_q, ota_vip_d;
  logic            ota_vin_q, ota_vin_d;
  logic [IW-1:0]   res_ch_q, res_ch_d;
  logic            res_bit_q, res_bit_d;
  logic [CW-1:0]   res_ones_q, res_ones_d;
  logic [CW-1:0]   res_vcnt_q, res_vcnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  digi_ota_rr_pick #(
    .NCH (NCH)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    vcnt_d     = vcnt_q;
    ota_vip_d  = 1'b0;
    ota_vin_d  = 1'b0;
    res_ch_d   = res_ch_q;
    res_bit_d  = res_bit_q;
    res_ones_d = res_ones_q;
    res_vcnt_d = res_vcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          cnt_d   = CNTW'(SETTLE - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        ota_vip_d = vip_ch[sel_q];
        ota_vin_d = vin_ch[sel_q];
        if (cnt_q == '0) begin
          ones_d  = '0;
          vcnt_d  = '0;
          cnt_d   = CNTW'(WINDOW - 1);
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        ota_vip_d = vip_ch[sel_q];
        ota_vin_d = vin_ch[sel_q];
        ones_d    = ones_q + CW'(ota_vld & ota_out);
        vcnt_d    = vcnt_q + CW'(ota_vld);
        if (cnt_q == '0) begin
          // Last sample edge: release the OTA drive so it reads 0 throughout REPORT.
          ota_vip_d  = 1'b0;
          ota_vin_d  = 1'b0;
          res_ch_d   = sel_q;
          res_ones_d = ones_d;
          res_vcnt_d = vcnt_d;
          res_bit_d  = ({ones_d, 1'b0} > {1'b0, vcnt_d});
          state_d    = S_REPORT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          ptr_d   = (sel_q == IW'(NCH - 1)) ? '0 : sel_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      ones_q     <= '0;
      vcnt_q     <= '0;
      ota_vip_q  <= 1'b0;
      ota_vin_q  <= 1'b0;
      res_ch_q   <= '0;
      res_bit_q  <= 1'b0;
      res_ones_q <= '0;
      res_vcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      vcnt_q     <= vcnt_d;
      ota_vip_q  <= ota_vip_d;
      ota_vin_q  <= ota_vin_d;
      res_ch_q   <= res_ch_d;
      res_bit_q  <= res_bit_d;
      res_ones_q <= res_ones_d;
      res_vcnt_q <= res_vcnt_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q != S_IDLE) begin
      gnt = NCH'(1) << sel_q;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_REPORT);
  assign ota_vip   = ota_vip_q;
  assign ota_vin   = ota_vin_q;
  assign res_ch    = res_ch_q;
  assign res_bit   = res_bit_q;
  assign res_ones  = res_ones_q;
  assign res_vcnt  = res_vcnt_q;

endmodule
